// File: rtl/pll_div_pkg.sv
// Shared types and sizing helpers for the multi-channel clock divider bank.
package pll_div_pkg;

  // Width of a divide ratio; the config struct below is built on it, so the
  // top-level DIV_W parameter must stay equal to this value.
  localparam int CFG_DIV_W = 8;

  // Default lock qualification length and the counter width it needs.
  localparam int LOCK_PERIODS_DEF = 16;
  localparam int LOCK_CW = $clog2(LOCK_PERIODS_DEF + 1);

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic                 bypass;
  } pll_div_cfg_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Lock counter width able to hold the value LOCK_PERIODS without wrapping.
  function automatic int lock_cw(input int periods);
    return $clog2(periods + 1);
  endfunction

endpackage

// File: rtl/pll_div_chan.sv
// One divider channel: period counter, active/pending config and lock tracking.
// A pending config only takes effect at a period boundary, so output periods
// are never cut short.
module pll_div_chan
  import pll_div_pkg::*;
#(
  parameter int RESET_DIV    = 2,
  parameter int LOCK_PERIODS = LOCK_PERIODS_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         cfg_wr,
  input  pll_div_cfg_t cfg,
  output logic         pending,
  output logic         clk_en,
  output logic         clk_level,
  output logic         lock
);

  localparam int LCW = lock_cw(LOCK_PERIODS);
  localparam logic [CFG_DIV_W-1:0] DIV_ONE   = CFG_DIV_W'(1);
  localparam logic [CFG_DIV_W-1:0] DIV_RST   = CFG_DIV_W'(RESET_DIV);
  localparam logic [CFG_DIV_W:0]   HALF_ONE  = (CFG_DIV_W + 1)'(1);
  localparam logic [LCW-1:0]       LOCK_ONE  = LCW'(1);
  localparam logic [LCW-1:0]       LOCK_TGT  = LCW'(LOCK_PERIODS);
  localparam logic [LCW-1:0]       LOCK_LAST = LCW'(LOCK_PERIODS - 1);

  pll_div_cfg_t         cur_q;
  pll_div_cfg_t         pend_cfg_q;
  logic                 pend_q;
  logic [CFG_DIV_W-1:0] cnt_q;
  logic                 lock_q;
  logic [LCW-1:0]       lock_cnt_q;

  logic [CFG_DIV_W-1:0] n;
  logic [CFG_DIV_W:0]   half;
  logic                 period_end;
  logic                 apply;
  logic                 cfg_change;
  pll_div_cfg_t         cfg_norm;

  // Divide ratio is stored already normalised (0 becomes 1), so n is the live ratio.
  assign n          = cur_q.div;
  assign half       = ({1'b0, n} + HALF_ONE) >> 1;
  assign period_end = cur_q.bypass | (cnt_q == (n - DIV_ONE));
  assign apply      = pend_q & period_end;
  assign cfg_change = (pend_cfg_q != cur_q);

  assign cfg_norm.div    = (cfg.div == '0) ? DIV_ONE : cfg.div;
  assign cfg_norm.bypass = cfg.bypass;

  // Outputs are forced low while reset is held; cnt resets to 0, which would
  // otherwise raise clk_en during reset.
  assign clk_en    = reset_n & (cur_q.bypass | (cnt_q == '0));
  assign clk_level = reset_n & (cur_q.bypass | ({1'b0, cnt_q} < half));
  assign lock      = reset_n & lock_q;
  assign pending   = pend_q;

  // Config staging: accept into the pending slot, promote it at a period end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_q.div         <= DIV_RST;
      cur_q.bypass      <= 1'b0;
      pend_cfg_q.div    <= DIV_RST;
      pend_cfg_q.bypass <= 1'b0;
      pend_q            <= 1'b0;
    end else begin
      if (apply) begin
        cur_q  <= pend_cfg_q;
        pend_q <= 1'b0;
      end
      if (cfg_wr) begin
        pend_cfg_q <= cfg_norm;
        pend_q     <= 1'b1;
      end
    end
  end

  // Period counter: wraps at the period end, held at 0 in bypass.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (period_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_ONE;
    end
  end

  // Lock qualification: count whole periods after a real change, saturating at lock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else if (apply && cfg_change) begin
      lock_q     <= pend_cfg_q.bypass;
      lock_cnt_q <= '0;
    end else if (cur_q.bypass) begin
      lock_q <= 1'b1;
    end else if (!lock_q && period_end) begin
      if (lock_cnt_q == LOCK_LAST) begin
        lock_q     <= 1'b1;
        lock_cnt_q <= LOCK_TGT;
      end else begin
        lock_cnt_q <= lock_cnt_q + LOCK_ONE;
      end
    end
  end

endmodule

// File: rtl/pll_div_bank.sv
// Bank of programmable integer clock dividers sharing one reference clock and
// one valid/ready reconfiguration port.
module pll_div_bank
  import pll_div_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DIV_W        = CFG_DIV_W,
  parameter int RESET_DIV    = 2,
  parameter int LOCK_PERIODS = LOCK_PERIODS_DEF,
  localparam int CHAN_W      = chan_w(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                io_cfg_valid,
  output logic                io_cfg_ready,
  input  logic [CHAN_W-1:0]   io_cfg_chan,
  input  logic [DIV_W-1:0]    io_cfg_div,
  input  logic                io_cfg_bypass,
  output logic [CHANNELS-1:0] io_clk_en,
  output logic [CHANNELS-1:0] io_clk_level,
  output logic [CHANNELS-1:0] io_lock,
  output logic                io_lock_all
);

  pll_div_cfg_t        cfg_in;
  logic [CHANNELS-1:0] cfg_wr;
  logic [CHANNELS-1:0] pend;

  assign cfg_in.div    = io_cfg_div;
  assign cfg_in.bypass = io_cfg_bypass;

  // Ready follows the addressed channel's pending slot; an unknown channel is
  // always ready so its request is consumed and dropped.
  always_comb begin
    io_cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (io_cfg_chan == CHAN_W'(i)) io_cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign cfg_wr[g] = io_cfg_valid & io_cfg_ready & (io_cfg_chan == CHAN_W'(g));

    pll_div_chan #(
      .RESET_DIV    (RESET_DIV),
      .LOCK_PERIODS (LOCK_PERIODS)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .cfg_wr    (cfg_wr[g]),
      .cfg       (cfg_in),
      .pending   (pend[g]),
      .clk_en    (io_clk_en[g]),
      .clk_level (io_clk_level[g]),
      .lock      (io_lock[g])
    );
  end

  assign io_lock_all = &io_lock;

endmodule

// File: tb/tb_pll_div_bank.sv
// Directed bench for pll_div_bank: a vector table for reset and the first
// reprogram, then hand-written sequences for the multi-cycle corner cases.
module tb_pll_div_bank;

  logic       clock;
  logic       reset_n;
  logic       io_cfg_valid;
  logic       io_cfg_ready;
  logic [1:0] io_cfg_chan;
  logic [7:0] io_cfg_div;
  logic       io_cfg_bypass;
  logic [3:0] io_clk_en;
  logic [3:0] io_clk_level;
  logic [3:0] io_lock;
  logic       io_lock_all;

  // Three-channel instance: channel 3 is out of range on the same 2-bit select.
  logic       rdy3;
  logic [2:0] en3;
  logic [2:0] lvl3;
  logic [2:0] lk3;
  logic       lk_all3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pll_div_bank #(
    .CHANNELS(4), .DIV_W(8), .RESET_DIV(2), .LOCK_PERIODS(5)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .io_cfg_valid(io_cfg_valid), .io_cfg_ready(io_cfg_ready),
    .io_cfg_chan(io_cfg_chan), .io_cfg_div(io_cfg_div), .io_cfg_bypass(io_cfg_bypass),
    .io_clk_en(io_clk_en), .io_clk_level(io_clk_level),
    .io_lock(io_lock), .io_lock_all(io_lock_all)
  );

  pll_div_bank #(
    .CHANNELS(3), .DIV_W(8), .RESET_DIV(2), .LOCK_PERIODS(5)
  ) dut3 (
    .clock(clock), .reset_n(reset_n),
    .io_cfg_valid(io_cfg_valid), .io_cfg_ready(rdy3),
    .io_cfg_chan(io_cfg_chan), .io_cfg_div(io_cfg_div), .io_cfg_bypass(io_cfg_bypass),
    .io_clk_en(en3), .io_clk_level(lvl3),
    .io_lock(lk3), .io_lock_all(lk_all3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       valid;
    logic [1:0] chan;
    logic [7:0] div;
    logic       byp;
    logic       rdy;
    logic [3:0] en;
    logic [3:0] lvl;
    logic [3:0] lk;
  } vec_t;

  vec_t tbl [0:19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cyc_step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_to(input int c);
    io_cfg_valid = 1'b0;
    while (cyc < c) cyc_step();
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d, input logic b);
    io_cfg_valid  = v;
    io_cfg_chan   = ch;
    io_cfg_div    = d;
    io_cfg_bypass = b;
  endtask

  initial begin
    int n;

    // Reset defaults: N=2 on every channel, lock after 5 periods (10 cycles).
    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1,
                 (i % 2 == 0) ? 4'hF : 4'h0,
                 (i % 2 == 0) ? 4'hF : 4'h0,
                 (i >= 10) ? 4'hF : 4'h0};
    // ch1 -> N=5 accepted at cnt=0, applied at the end of the current 2-cycle period.
    tbl[12] = '{1'b1, 2'd1, 8'd5, 1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111};
    tbl[13] = '{1'b0, 2'd1, 8'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111};
    tbl[14] = '{1'b0, 2'd1, 8'd0, 1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1101};
    tbl[15] = '{1'b0, 2'd1, 8'd0, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b1101};
    tbl[16] = '{1'b0, 2'd1, 8'd0, 1'b0, 1'b1, 4'b1101, 4'b1111, 4'b1101};
    tbl[17] = '{1'b0, 2'd1, 8'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1101};
    tbl[18] = '{1'b0, 2'd1, 8'd0, 1'b0, 1'b1, 4'b1101, 4'b1101, 4'b1101};
    tbl[19] = '{1'b0, 2'd1, 8'd0, 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b1101};

    reset_n = 1'b0;
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_en", io_clk_en, 4'h0);
    chk("rst_level", io_clk_level, 4'h0);
    chk("rst_lock", io_lock, 4'h0);
    chk("rst_lock_all", io_lock_all, 1'b0);
    reset_n = 1'b1;
    cyc = 0;

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].valid, tbl[r].chan, tbl[r].div, tbl[r].byp);
      #3;
      chk("tbl_ready", io_cfg_ready, tbl[r].rdy);
      chk("tbl_en", io_clk_en, tbl[r].en);
      chk("tbl_level", io_clk_level, tbl[r].lvl);
      chk("tbl_lock", io_lock, tbl[r].lk);
      chk("tbl_lock_all", io_lock_all, &tbl[r].lk);
      cyc_step();
    end

    // ch1 periods end at 18,23,28,33,38 -> relock at 39.
    idle_to(38); #3;
    chk("ch1_relock_pre", io_lock[1], 1'b0);
    cyc_step(); #3;
    chk("ch1_relock", io_lock, 4'hF);
    chk("ch1_relock_all", io_lock_all, 1'b1);

    // ch2 div=0 and ch3 div=1: both become divide-by-1.
    idle_to(40);
    drive(1'b1, 2'd2, 8'd0, 1'b0); #3;
    chk("ch2_wr_ready", io_cfg_ready, 1'b1);
    cyc_step();
    drive(1'b1, 2'd3, 8'd1, 1'b0); #3;
    chk("ch3_wr_ready", io_cfg_ready, 1'b1);
    cyc_step();
    idle_to(45); #3;
    chk("div1_en_a", io_clk_en[3:2], 2'b11);
    chk("div1_lvl_a", io_clk_level[3:2], 2'b11);
    cyc_step(); #3;
    chk("div1_en_b", io_clk_en[3:2], 2'b11);
    chk("div1_lvl_b", io_clk_level[3:2], 2'b11);
    chk("ch2_lock_pre", io_lock[2], 1'b0);
    cyc_step(); #3;
    chk("ch2_lock", io_lock[2], 1'b1);
    idle_to(48); #3;
    chk("ch3_lock_pre", io_lock[3], 1'b0);
    cyc_step(); #3;
    chk("ch3_lock", io_lock[3], 1'b1);

    // ch0 bypass, applied at the end of cycle 51.
    idle_to(50);
    drive(1'b1, 2'd0, 8'd7, 1'b1);
    cyc_step();
    idle_to(52); #3;
    chk("byp_en_a", io_clk_en[0], 1'b1);
    chk("byp_lock", io_lock[0], 1'b1);
    cyc_step(); #3;
    chk("byp_en_b", io_clk_en[0], 1'b1);
    chk("byp_lvl_b", io_clk_level[0], 1'b1);
    // Leave bypass with N=3: applies next cycle since bypass is always a period end.
    cyc_step();
    drive(1'b1, 2'd0, 8'd3, 1'b0); #3;
    chk("unbyp_ready", io_cfg_ready, 1'b1);
    cyc_step();
    io_cfg_valid = 1'b0; #3;
    chk("unbyp_en_55", io_clk_en[0], 1'b1);
    chk("unbyp_lock_55", io_lock[0], 1'b1);
    cyc_step(); #3;
    chk("div3_en_56", io_clk_en[0], 1'b1);
    chk("div3_lvl_56", io_clk_level[0], 1'b1);
    chk("div3_lock_56", io_lock[0], 1'b0);
    cyc_step(); #3;
    chk("div3_en_57", io_clk_en[0], 1'b0);
    chk("div3_lvl_57", io_clk_level[0], 1'b1);
    cyc_step(); #3;
    chk("div3_en_58", io_clk_en[0], 1'b0);
    chk("div3_lvl_58", io_clk_level[0], 1'b0);
    cyc_step(); #3;
    chk("div3_en_59", io_clk_en[0], 1'b1);
    idle_to(70); #3;
    chk("ch0_lock_pre", io_lock[0], 1'b0);
    cyc_step(); #3;
    chk("ch0_lock", io_lock[0], 1'b1);

    // Back-to-back writes to ch1 (N=5, cnt=1 at cycle 75): second stalls until 79.
    idle_to(75);
    drive(1'b1, 2'd1, 8'd4, 1'b0); #3;
    chk("b2b_first_ready", io_cfg_ready, 1'b1);
    cyc_step();
    drive(1'b1, 2'd1, 8'd6, 1'b0); #3;
    chk("b2b_stall_ready", io_cfg_ready, 1'b0);
    n = 0;
    while (!io_cfg_ready && n < 10) begin
      cyc_step(); #3;
      n++;
    end
    chk("b2b_accept_cycle", cyc, 79);
    cyc_step();
    drive(1'b0, 2'd1, 8'd0, 1'b0); #3;
    chk("b2b_pending_ready", io_cfg_ready, 1'b0);
    cyc_step();
    io_cfg_chan = 2'd0; #3;
    chk("other_chan_ready", io_cfg_ready, 1'b1);
    idle_to(83); #3;
    chk("div6_en_83", io_clk_en[1], 1'b1);
    idle_to(86); #3;
    chk("div6_en_86", io_clk_en[1], 1'b0);

    // Accept in the period-end cycle (cnt=5 at 88): applies at 94, not 88.
    idle_to(88);
    drive(1'b1, 2'd1, 8'd3, 1'b0); #3;
    chk("late_wr_ready", io_cfg_ready, 1'b1);
    cyc_step();
    io_cfg_valid = 1'b0; #3;
    chk("late_en_89", io_clk_en[1], 1'b1);
    idle_to(91); #3;
    chk("late_lvl_91", io_clk_level[1], 1'b1);
    cyc_step(); #3;
    chk("late_lvl_92", io_clk_level[1], 1'b0);
    idle_to(94); #3;
    chk("late_en_94", io_clk_en[1], 1'b0);
    cyc_step(); #3;
    chk("late_en_95", io_clk_en[1], 1'b1);
    cyc_step(); #3;
    chk("late_en_96", io_clk_en[1], 1'b0);
    idle_to(98); #3;
    chk("late_en_98", io_clk_en[1], 1'b1);
    idle_to(109); #3;
    chk("ch1_lock3_pre", io_lock[1], 1'b0);
    cyc_step(); #3;
    chk("ch1_lock3", io_lock[1], 1'b1);

    // Identical rewrite of ch1 (N=3): lock must survive the apply at 115.
    idle_to(112);
    drive(1'b1, 2'd1, 8'd3, 1'b0); #3;
    chk("same_wr_ready", io_cfg_ready, 1'b1);
    cyc_step();
    io_cfg_valid = 1'b0; #3;
    chk("same_pending_ready", io_cfg_ready, 1'b0);
    idle_to(116); #3;
    chk("same_applied_ready", io_cfg_ready, 1'b1);
    chk("same_lock", io_lock[1], 1'b1);
    chk("same_lock_all", io_lock_all, 1'b1);
    chk("same_en_116", io_clk_en[1], 1'b1);

    // Reset with a pending ch0 write (div=7) in flight.
    idle_to(119);
    drive(1'b1, 2'd0, 8'd7, 1'b0);
    cyc_step();
    io_cfg_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_en", io_clk_en, 4'h0);
    chk("midrst_level", io_clk_level, 4'h0);
    chk("midrst_lock", io_lock, 4'h0);
    chk("midrst_lock_all", io_lock_all, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    #3;
    chk("rel_en_0", io_clk_en, 4'hF);
    chk("rel_lvl_0", io_clk_level, 4'hF);
    cyc_step(); #3;
    chk("rel_en_1", io_clk_en, 4'h0);
    idle_to(3); #3;
    chk("rel_en_3", io_clk_en[0], 1'b0);
    chk("rel_lvl_3", io_clk_level[0], 1'b0);
    cyc_step(); #3;
    chk("rel_en_4", io_clk_en[0], 1'b1);
    idle_to(10); #3;
    chk("rel_lock_10", io_lock, 4'hF);

    // Out-of-range channel on the 3-channel instance: accepted and dropped.
    idle_to(12);
    drive(1'b1, 2'd3, 8'd7, 1'b1); #3;
    chk("oor_ready", rdy3, 1'b1);
    cyc_step();
    io_cfg_valid = 1'b0; #3;
    chk("oor_ready_after", rdy3, 1'b1);
    cyc_step(); #3;
    chk("oor_en_14", en3, 3'b111);
    cyc_step(); #3;
    chk("oor_en_15", en3, 3'b000);
    chk("oor_lvl_15", lvl3, 3'b000);
    chk("oor_lock_15", lk3, 3'b111);
    chk("oor_lock_all_15", lk_all3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
